// File: rtl/mesh_loader.sv
// mesh_loader
//   Receives a serialized mesh over a valid/ready word stream and writes it
//   into the OBJ RAM. It checks the header against RAM capacity, pulses a
//   multi-cycle start to subsurf, and then waits for subsurf to go idle.
//
//   Stream layout: word0 = vertex_count, word1 = face_count, then 3 words per
//   vertex and 3 words per face. Word n is written to RAM address n.
//
// Ports
//   clk, rst        system clock; synchronous active-high reset
//   load            single-cycle request to start receiving (IDLE/ERROR only)
//   in_data/valid   stream word and its valid flag
//   in_ready        block can accept a word this cycle
//   ram_en/a/we/di  OBJ RAM write port, all zero except on a transfer cycle
//   ss_start        start to subsurf, held START_CYCLES cycles
//   ss_busy         busy from subsurf
//   busy            high from an accepted load until done or err
//   done            one-cycle pulse when subsurf finishes
//   err             header error, held until the next load
//   vertex_count    latched header word 0
//   face_count      latched header word 1
//   dbg_state       current FSM state
//
// Handshake: a word transfers on every cycle where in_valid & in_ready.
// in_ready is a function of state only, never of in_valid, and the RAM write
// for a transfer is issued combinationally in that same cycle.
module mesh_loader #(
  parameter int ADDR_WIDTH   = 11,
  parameter int START_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [31:0]           in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [3:0]            ram_we,
  output logic [31:0]           ram_di,
  output logic                  ss_start,
  input  logic                  ss_busy,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           vertex_count,
  output logic [31:0]           face_count,
  output logic [2:0]            dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR_V = 3'd1;
  localparam logic [2:0] S_HDR_F = 3'd2;
  localparam logic [2:0] S_BODY  = 3'd3;
  localparam logic [2:0] S_KICK  = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam int KW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [KW-1:0]         kick_cnt;
  logic                  xfer;
  logic [34:0]           total;
  logic                  hdr_bad;

  assign in_ready  = (state == S_HDR_V) || (state == S_HDR_F) || (state == S_BODY);
  assign xfer      = in_valid & in_ready;

  assign ram_en    = xfer;
  assign ram_we    = xfer ? 4'hF : 4'h0;
  assign ram_a     = xfer ? addr : '0;
  assign ram_di    = xfer ? in_data : 32'd0;

  assign busy      = (state != S_IDLE) && (state != S_ERROR);
  assign err       = (state == S_ERROR);
  assign done      = (state == S_WAIT) && !ss_busy;
  assign dbg_state = state;

  // Word count of the whole mesh, evaluated while face_count is on in_data.
  // 35 bits hold (2**33-2)*3+2 without truncation.
  assign total   = ({3'b000, vertex_count} + {3'b000, in_data}) * 35'd3 + 35'd2;
  assign hdr_bad = (vertex_count == 32'd0) || (in_data == 32'd0) ||
                   (total > (35'd1 << ADDR_WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      addr         <= '0;
      remaining    <= '0;
      kick_cnt     <= '0;
      ss_start     <= 1'b0;
      vertex_count <= 32'd0;
      face_count   <= 32'd0;
    end else begin
      case (state)
        S_IDLE, S_ERROR: begin
          if (load) begin
            state <= S_HDR_V;
            addr  <= '0;
          end
        end
        S_HDR_V: begin
          if (xfer) begin
            vertex_count <= in_data;
            addr         <= ADDR_WIDTH'(1);
            state        <= S_HDR_F;
          end
        end
        S_HDR_F: begin
          if (xfer) begin
            face_count <= in_data;
            if (hdr_bad) begin
              state <= S_ERROR;
            end else begin
              state     <= S_BODY;
              addr      <= ADDR_WIDTH'(2);
              // total is at most 2**ADDR_WIDTH here, so the low bits suffice
              remaining <= total[ADDR_WIDTH:0] - (ADDR_WIDTH+1)'(2);
            end
          end
        end
        S_BODY: begin
          if (xfer) begin
            if (remaining == (ADDR_WIDTH+1)'(1)) begin
              // last word: leave addr alone so it never wraps past the top
              state    <= S_KICK;
              ss_start <= 1'b1;
              kick_cnt <= '0;
            end else begin
              addr      <= addr + ADDR_WIDTH'(1);
              remaining <= remaining - (ADDR_WIDTH+1)'(1);
            end
          end
        end
        S_KICK: begin
          if (kick_cnt == KW'(START_CYCLES - 1)) begin
            ss_start <= 1'b0;
            state    <= S_WAIT;
          end else begin
            kick_cnt <= kick_cnt + KW'(1);
          end
        end
        S_WAIT: begin
          if (!ss_busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesh_loader.sv
module tb_mesh_loader;

  localparam int AW  = 11;
  localparam int CAP = 1 << AW;
  localparam int W   = AW + 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [31:0]   in_data = 32'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          ram_en;
  logic [AW-1:0] ram_a;
  logic [3:0]    ram_we;
  logic [31:0]   ram_di;
  logic          ss_start;
  logic          ss_busy = 1'b0;
  logic          busy;
  logic          done;
  logic          err;
  logic [31:0]   vertex_count;
  logic [31:0]   face_count;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // expected RAM writes, {addr, data}, in stream order
  logic [W-1:0] exp_q[$];

  int start_cnt = 0;
  int start_run = 0;
  int last_run  = 0;
  int done_cnt  = 0;
  int last_wr_addr = -1;

  mesh_loader #(.ADDR_WIDTH(AW), .START_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .load(load), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ram_en(ram_en), .ram_a(ram_a), .ram_we(ram_we),
    .ram_di(ram_di), .ss_start(ss_start), .ss_busy(ss_busy), .busy(busy),
    .done(done), .err(err), .vertex_count(vertex_count), .face_count(face_count),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: the whole-mesh word count and header acceptance rule
  function automatic longint mesh_total(input longint v, input longint f);
    return (v + f) * 3 + 2;
  endfunction

  function automatic bit mesh_ok(input longint v, input longint f);
    return (v != 0) && (f != 0) && (mesh_total(v, f) <= CAP);
  endfunction

  function automatic logic [31:0] mesh_word(input int i, input int v, input int f);
    if (i == 0) return 32'(v);
    if (i == 1) return 32'(f);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0000_9E37);
  endfunction

  // scoreboard: every cycle the RAM port must either be silent or carry the
  // next expected write
  always @(negedge clk) begin
    if (ram_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", 64'(ram_a), 64'hFFFF_FFFF);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(ram_a), 64'(e[W-1:32]));
        chk("wr_data", 64'(ram_di), 64'(e[31:0]));
        chk("wr_we", 64'(ram_we), 64'hF);
        chk("wr_needs_valid", 64'(in_valid), 64'd1);
        last_wr_addr = int'(ram_a);
      end
    end else begin
      chk("idle_bus", {21'd0, ram_a, ram_we, ram_di}, 64'd0);
    end
    if (ss_start) begin
      start_cnt++;
      start_run++;
    end else if (start_run != 0) begin
      last_run  = start_run;
      start_run = 0;
    end
    if (done) done_cnt++;
  end

  // driver tasks
  task automatic pulse_load();
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd, input bit with_load);
    int guard;
    bit rdy;
    guard = 0;
    if (rnd) begin
      while ($urandom_range(0, 2) == 0 && guard < 8) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        guard++;
      end
    end
    in_data  = w;
    in_valid = 1'b1;
    load     = with_load;
    guard    = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      load = 1'b0;
      guard++;
    end while (!rdy && guard < 50);
    if (!rdy) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_mesh(input int v, input int f, input bit rnd,
                          input int load_at, input bit load_in_wait);
    bit ok;
    int n;
    int guard;
    ok = mesh_ok(v, f);
    n  = ok ? int'(mesh_total(v, f)) : 2;
    for (int i = 0; i < n; i++) exp_q.push_back({AW'(i), mesh_word(i, v, f)});
    start_cnt = 0; last_run = 0; done_cnt = 0;

    pulse_load();
    @(negedge clk);
    chk("busy_after_load", 64'(busy), 64'd1);
    chk("err_cleared", 64'(err), 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < n; i++) send_word(mesh_word(i, v, f), rnd, i == load_at);
    in_valid = 1'b0;

    if (!ok) begin
      in_data  = 32'hDEAD_BEEF;
      in_valid = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("err_set", 64'(err), 64'd1);
      chk("err_busy", 64'(busy), 64'd0);
      chk("err_ready", 64'(in_ready), 64'd0);
      chk("err_start", 64'(start_cnt), 64'd0);
      in_valid = 1'b0;
      chk("err_exp_drained", 64'(exp_q.size()), 64'd0);
      return;
    end

    guard = 0;
    @(negedge clk);
    while (!ss_start && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("start_seen", 64'(ss_start), 64'd1);
    @(posedge clk); #1;
    ss_busy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      load = load_in_wait && (k == 7);
      @(posedge clk); #1;
      load = 1'b0;
    end
    ss_busy = 1'b0;
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_in_done", 64'(busy), 64'd1);
    @(negedge clk);
    chk("done_once", 64'(done), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("start_run_len", 64'(last_run), 64'd3);
    chk("start_total", 64'(start_cnt), 64'd3);
    chk("vertex_count", 64'(vertex_count), 64'(v));
    chk("face_count", 64'(face_count), 64'(f));
    chk("exp_drained", 64'(exp_q.size()), 64'd0);
    chk("last_wr_addr", 64'(last_wr_addr), 64'(n - 1));
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_ram"}, {21'd0, ram_en, ram_a, ram_we, ram_di} , 64'd0);
    chk({tag, "_start"}, 64'(ss_start), 64'd0);
    chk({tag, "_flags"}, {61'd0, busy, done, err}, 64'd0);
    chk({tag, "_counts"}, {vertex_count, face_count}, 64'd0);
  endtask

  initial begin
    // pin the model with hand-computed header arithmetic
    chk("model_total_8_12", 64'(mesh_total(8, 12)), 64'd62);
    chk("model_total_600_82", 64'(mesh_total(600, 82)), 64'd2048);
    chk("model_ok_600_83", 64'(mesh_ok(600, 83)), 64'd0);
    chk("model_total_4_4", 64'(mesh_total(4, 4)), 64'd26);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;

    run_mesh(8, 12, 1'b0, -1, 1'b0);
    run_mesh(8, 12, 1'b1, -1, 1'b0);
    run_mesh(600, 82, 1'b0, -1, 1'b0);
    chk("cap_last_addr", 64'(last_wr_addr), 64'd2047);
    run_mesh(600, 83, 1'b0, -1, 1'b0);
    run_mesh(0, 5, 1'b0, -1, 1'b0);
    run_mesh(4, 4, 1'b0, -1, 1'b0);

    // reset in the middle of the body, after word 20 has been written
    for (int i = 0; i <= 20; i++) exp_q.push_back({AW'(i), mesh_word(i, 8, 12)});
    pulse_load();
    for (int i = 0; i <= 20; i++) send_word(mesh_word(i, 8, 12), 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    chk("mid_reset_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    run_mesh(8, 12, 1'b0, -1, 1'b0);

    // load pulses during BODY and WAIT must be ignored
    run_mesh(8, 12, 1'b0, 30, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
